// File: rtl/hdmi_linebuf_pkg.sv
// Shared types and constants for the HDMI ping-pong line buffer.
// Raster geometry, pixel type, writer/output-select states and the fallback colour-bar table.
package hdmi_linebuf_pkg;

  localparam int H_PIXEL     = 800;
  localparam int V_PIXEL     = 600;
  localparam int H_TOT_PIXEL = 1056;
  localparam int V_TOT_PIXEL = 628;
  localparam int CNT_W       = 26;
  localparam int RGB_W       = 24;
  localparam int X_W         = $clog2(H_PIXEL);
  localparam int A_W         = $clog2(2 * H_PIXEL);

  typedef logic [RGB_W-1:0] rgb888_t;

  typedef enum logic [1:0] {WAIT_SOF, FILL, HOLD} wr_state_e;
  typedef enum logic [1:0] {SEL_BLANK, SEL_RAM, SEL_FILL} out_sel_e;

  localparam rgb888_t BAR_BLACK   = 24'h000000;
  localparam rgb888_t BAR_RED     = 24'hFF0000;
  localparam rgb888_t BAR_GREEN   = 24'h00FF00;
  localparam rgb888_t BAR_BLUE    = 24'h0000FF;
  localparam rgb888_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb888_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb888_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb888_t BAR_CYAN    = 24'h00FFFF;

  // Eight 100-pixel bars; compares instead of a divider.
  function automatic rgb888_t bar_colour(input logic [X_W-1:0] x);
    rgb888_t c;
    if      (x < X_W'(100)) c = BAR_BLACK;
    else if (x < X_W'(200)) c = BAR_RED;
    else if (x < X_W'(300)) c = BAR_GREEN;
    else if (x < X_W'(400)) c = BAR_BLUE;
    else if (x < X_W'(500)) c = BAR_WHITE;
    else if (x < X_W'(600)) c = BAR_YELLOW;
    else if (x < X_W'(700)) c = BAR_MAGENTA;
    else                    c = BAR_CYAN;
    return c;
  endfunction

  function automatic logic [A_W-1:0] ram_addr(input logic bank, input logic [X_W-1:0] x);
    return bank ? (A_W'(x) + A_W'(H_PIXEL)) : A_W'(x);
  endfunction

endpackage

// File: rtl/hdmi_line_buffer_if.sv
// Upstream pixel stream plus transceiver raster/colour signals of the line buffer.
// master = producer/transceiver side, slave = line buffer.
interface hdmi_line_buffer_if;
  import hdmi_linebuf_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  rgb888_t          in_data;
  logic [CNT_W-1:0] cntX;
  logic [CNT_W-1:0] cntY;
  logic [7:0]       red;
  logic [7:0]       green;
  logic [7:0]       blue;
  logic             frame_req;
  logic             underflow;

  modport master (
    output in_valid, in_sof, in_data, cntX, cntY,
    input  in_ready, red, green, blue, frame_req, underflow
  );

  modport slave (
    input  in_valid, in_sof, in_data, cntX, cntY,
    output in_ready, red, green, blue, frame_req, underflow
  );

endinterface

// File: rtl/hdmi_linebuf_ram.sv
// Dual-port store for both line banks: one write port, registered read (data 1 cycle after raddr).
// No backpressure: writes and reads are accepted every cycle.
module hdmi_linebuf_ram
  import hdmi_linebuf_pkg::*;
(
  input  logic           pixclk,
  input  logic           we,
  input  logic [A_W-1:0] waddr,
  input  rgb888_t        wdata,
  input  logic [A_W-1:0] raddr,
  output rgb888_t        rdata
);

  rgb888_t mem [2*H_PIXEL];
  rgb888_t rdata_q;

  always_ff @(posedge pixclk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hdmi_line_buffer.sv
// Ping-pong two-line buffer feeding the HDMI raster; RGB and frame_req appear 1 cycle after cntX/cntY.
// in_ready drops while both banks are full; LINEBUF_FALLBACK_PATTERN_EN shows colour bars on underflow lines.
module hdmi_line_buffer
  import hdmi_linebuf_pkg::*;
(
  input  logic              pixclk,
  input  logic              rst_n,
  hdmi_line_buffer_if.slave bus
);

  wr_state_e      state_q, state_d;
  logic [1:0]     full_q, full_d, full_rd;
  logic           wr_bank_q, wr_bank_d;
  logic           rd_bank_q, rd_bank_d;
  logic [X_W-1:0] wr_addr_q, wr_addr_d;
  logic           in_ready_q, in_ready_d;
  logic           line_ok_q, line_ok_d;
  out_sel_e       sel_q, sel_d;
  rgb888_t        fill_q, fill_d;
  logic           underflow_q, underflow_d;
  logic           frame_req_q, frame_req_d;

  logic           active, line_ok, xfer;
  logic           ram_we;
  logic [A_W-1:0] ram_waddr, ram_raddr;
  rgb888_t        ram_rdata, rgb;

  hdmi_linebuf_ram u_ram (
    .pixclk (pixclk),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (bus.in_data),
    .raddr  (ram_raddr),
    .rdata  (ram_rdata)
  );

  always_comb begin
    full_rd     = full_q;
    rd_bank_d   = rd_bank_q;
    sel_d       = SEL_BLANK;
    fill_d      = '0;
    underflow_d = underflow_q;
    active      = (bus.cntX < CNT_W'(H_PIXEL)) && (bus.cntY < CNT_W'(V_PIXEL));
    // The line decision is taken at cntX==0 and held for the rest of the line.
    line_ok     = (active && bus.cntX == '0) ? full_q[rd_bank_q] : line_ok_q;
    line_ok_d   = line_ok;
    ram_raddr   = ram_addr(rd_bank_q, bus.cntX[X_W-1:0]);
    frame_req_d = (bus.cntX == '0) && (bus.cntY == CNT_W'(V_TOT_PIXEL - 1));

    if (active) begin
      if (line_ok) begin
        sel_d = SEL_RAM;
        if (bus.cntX == CNT_W'(H_PIXEL - 1)) begin
          full_rd[rd_bank_q] = 1'b0;
          rd_bank_d          = !rd_bank_q;
        end
      end else begin
        sel_d       = SEL_FILL;
        underflow_d = 1'b1;
`ifdef LINEBUF_FALLBACK_PATTERN_EN
        fill_d      = bar_colour(bus.cntX[X_W-1:0]);
`else
        fill_d      = '0;
`endif
      end
    end

    // Writer sees the flags after this cycle's reader release.
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    full_d    = full_rd;
    ram_we    = 1'b0;
    ram_waddr = ram_addr(wr_bank_q, wr_addr_q);
    xfer      = bus.in_valid && in_ready_q;

    if (xfer && bus.in_sof) begin
      full_d    = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      line_ok_d = 1'b0;
      ram_we    = 1'b1;
      ram_waddr = ram_addr(1'b0, '0);
      wr_addr_d = X_W'(1);
      state_d   = FILL;
    end else begin
      unique case (state_q)
        WAIT_SOF: ;
        FILL: begin
          if (xfer) begin
            ram_we = 1'b1;
            if (wr_addr_q == X_W'(H_PIXEL - 1)) begin
              full_d[wr_bank_q] = 1'b1;
              wr_bank_d         = !wr_bank_q;
              wr_addr_d         = '0;
              if (full_rd[!wr_bank_q]) state_d = HOLD;
            end else begin
              wr_addr_d = wr_addr_q + X_W'(1);
            end
          end
        end
        HOLD: if (!full_rd[wr_bank_q]) state_d = FILL;
        default: state_d = WAIT_SOF;
      endcase
    end
    in_ready_d = (state_d != HOLD);
  end

  always_ff @(posedge pixclk) begin
    if (!rst_n) begin
      state_q     <= WAIT_SOF;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      in_ready_q  <= 1'b0;
      line_ok_q   <= 1'b0;
      sel_q       <= SEL_BLANK;
      fill_q      <= '0;
      underflow_q <= 1'b0;
      frame_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_addr_q   <= wr_addr_d;
      in_ready_q  <= in_ready_d;
      line_ok_q   <= line_ok_d;
      sel_q       <= sel_d;
      fill_q      <= fill_d;
      underflow_q <= underflow_d;
      frame_req_q <= frame_req_d;
    end
  end

  always_comb begin
    unique case (sel_q)
      SEL_RAM:  rgb = ram_rdata;
      SEL_FILL: rgb = fill_q;
      default:  rgb = '0;
    endcase
  end

  assign bus.red       = rgb[23:16];
  assign bus.green     = rgb[15:8];
  assign bus.blue      = rgb[7:0];
  assign bus.in_ready  = in_ready_q;
  assign bus.frame_req = frame_req_q;
  assign bus.underflow = underflow_q;

endmodule
